// File: rtl/mm_register.sv
// Memory-mapped register bank: byte-enable writes, registered read port, flat output bus.
// Optional MM_REGISTER_ADDR_WRAP_EN: decode only the low index bits of address.
module mm_register #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic [NUM_REGS*DATA_WIDTH-1:0] register,
    input  logic                           readEnable,
    input  logic                           writeEnable,
    input  logic [DATA_WIDTH/8-1:0]        writeByteEnable,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic [DATA_WIDTH-1:0]          writeData,
    output logic [DATA_WIDTH-1:0]          readData
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regFile_r [NUM_REGS];
    logic [DATA_WIDTH-1:0] readData_r;
    logic                  inRange_s;
    logic [IDX_W-1:0]      index_s;
    logic [DATA_WIDTH-1:0] readMux_s;

    function automatic logic [DATA_WIDTH-1:0] mergeBytes(
        input logic [DATA_WIDTH-1:0] oldValue,
        input logic [DATA_WIDTH-1:0] newValue,
        input logic [NUM_BYTES-1:0]  byteEnable
    );
        logic [DATA_WIDTH-1:0] result;
        result = oldValue;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (byteEnable[b]) begin
                result[b*8 +: 8] = newValue[b*8 +: 8];
            end else begin
                result[b*8 +: 8] = oldValue[b*8 +: 8];
            end
        end
        return result;
    endfunction

    // Address decode: register index and whether it names an existing register.
    always_comb begin
        inRange_s = 1'b0;
        index_s   = '0;
`ifdef MM_REGISTER_ADDR_WRAP_EN
        if (NUM_REGS == 1) begin
            inRange_s = 1'b1;
            index_s   = '0;
        end else begin
            index_s   = address[IDX_W-1:0];
            inRange_s = ({1'b0, index_s} < (IDX_W+1)'(NUM_REGS));
        end
`else
        index_s   = address[IDX_W-1:0];
        inRange_s = ({1'b0, address} < (ADDR_WIDTH+1)'(NUM_REGS));
`endif
    end

    // Read mux; out-of-range addresses read as zero.
    always_comb begin
        readMux_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (inRange_s && (index_s == IDX_W'(i))) begin
                readMux_s = regFile_r[i];
            end else begin
                readMux_s = readMux_s;
            end
        end
    end

    // Register storage with byte-lane writes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (writeEnable && inRange_s && (index_s == IDX_W'(i))) begin
                    regFile_r[i] <= mergeBytes(regFile_r[i], writeData, writeByteEnable);
                end
            end
        end
    end

    // Registered read port; samples the pre-write value on a same-edge access.
    always_ff @(posedge clock) begin
        if (!reset) begin
            readData_r <= '0;
        end else if (readEnable) begin
            readData_r <= readMux_s;
        end
    end

    assign readData = readData_r;

    for (genvar g = 0; g < NUM_REGS; g++) begin : gRegOut
        assign register[g*DATA_WIDTH +: DATA_WIDTH] = regFile_r[g];
    end

endmodule

// File: tb/tb_mm_register.sv
// Self-checking bench for mm_register: three bank sizes on one bus, directed plan then random traffic.
module tb_mm_register;

    logic        clock = 1'b0;
    logic        reset;
    logic        readEnable;
    logic [2:0]  weVec;
    logic [3:0]  writeByteEnable;
    logic [7:0]  address;
    logic [31:0] writeData;
    logic [31:0] reg1, rd1, rd2, rd3;
    logic [63:0] reg2;
    logic [95:0] reg3;

    int total = 0;
    int bad   = 0;
    int nRegs [3] = '{1, 2, 3};
    logic [31:0] mdl [3][3];
    logic [31:0] mrd [3];

    always #5 clock = ~clock;

    mm_register #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(1)) dut1 (
        .clock(clock), .reset(reset), .register(reg1), .readEnable(readEnable),
        .writeEnable(weVec[0]), .writeByteEnable(writeByteEnable), .address(address),
        .writeData(writeData), .readData(rd1));
    mm_register #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(2)) dut2 (
        .clock(clock), .reset(reset), .register(reg2), .readEnable(readEnable),
        .writeEnable(weVec[1]), .writeByteEnable(writeByteEnable), .address(address),
        .writeData(writeData), .readData(rd2));
    mm_register #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(3)) dut3 (
        .clock(clock), .reset(reset), .register(reg3), .readEnable(readEnable),
        .writeEnable(weVec[2]), .writeByteEnable(writeByteEnable), .address(address),
        .writeData(writeData), .readData(rd3));

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Register index addressed, or -1 when the access falls outside the bank.
    function automatic int resolve(input int addr, input int n);
        int a;
        a = addr;
`ifdef MM_REGISTER_ADDR_WRAP_EN
        if (n == 1) return 0;
        begin
            int k;
            k = 1;
            while ((1 << k) < n) k++;
            a = addr % (1 << k);
        end
`endif
        return (a < n) ? a : -1;
    endfunction

    function automatic logic [95:0] expBus(input int inst);
        logic [95:0] e;
        e = '0;
        for (int r = 0; r < nRegs[inst]; r++) e[r*32 +: 32] = mdl[inst][r];
        return e;
    endfunction

    // Advance the model by one edge, clock the DUTs, compare every output.
    task automatic tick();
        for (int i = 0; i < 3; i++) begin
            int idx;
            if (!reset) begin
                for (int r = 0; r < 3; r++) mdl[i][r] = 32'h0;
                mrd[i] = 32'h0;
            end else begin
                idx = resolve(int'(address), nRegs[i]);
                if (readEnable) mrd[i] = (idx >= 0) ? mdl[i][idx] : 32'h0;
                if (weVec[i] && idx >= 0) begin
                    for (int b = 0; b < 4; b++)
                        if (writeByteEnable[b]) mdl[i][idx][b*8 +: 8] = writeData[b*8 +: 8];
                end
            end
        end
        @(posedge clock);
        #1;
        chk("reg1", {64'h0, reg1}, expBus(0));
        chk("reg2", {32'h0, reg2}, expBus(1));
        chk("reg3", reg3, expBus(2));
        chk("rd1", {64'h0, rd1}, {64'h0, mrd[0]});
        chk("rd2", {64'h0, rd2}, {64'h0, mrd[1]});
        chk("rd3", {64'h0, rd3}, {64'h0, mrd[2]});
    endtask

    initial begin
        reset = 1'b0; readEnable = 1'b1; weVec = 3'b111; writeByteEnable = 4'hF;
        address = 8'h00; writeData = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) tick();
        chk("reset_reg2", {32'h0, reg2}, 96'h0);
        chk("reset_rd1", {64'h0, rd1}, 96'h0);

        reset = 1'b1; readEnable = 1'b0; weVec = 3'b001; writeData = 32'hAAAAAAAA;
        tick();
        chk("plan_n1_write", {64'h0, reg1}, {64'h0, 32'hAAAAAAAA});
        chk("plan_n2_idle", {32'h0, reg2}, 96'h0);

        weVec = 3'b010; writeData = 32'hBBBBBBBB;
        tick();
        chk("plan_n2_w0", {32'h0, reg2}, {32'h0, 64'h00000000BBBBBBBB});
        address = 8'h01; writeData = 32'hCCCCCCCC;
        tick();
        chk("plan_n2_w1", {32'h0, reg2}, {32'h0, 64'hCCCCCCCCBBBBBBBB});

        weVec = 3'b000; readEnable = 1'b1; address = 8'h00;
        tick();
        chk("plan_read_n1", {64'h0, rd1}, {64'h0, 32'hAAAAAAAA});
        chk("plan_read_n2", {64'h0, rd2}, {64'h0, 32'hBBBBBBBB});
        readEnable = 1'b0; address = 8'h01;
        tick();
        chk("plan_read_hold", {64'h0, rd2}, {64'h0, 32'hBBBBBBBB});

        weVec = 3'b100; address = 8'h00; writeData = 32'h11223344;
        tick();
        writeData = 32'hAABBCCDD; writeByteEnable = 4'h5;
        tick();
        chk("plan_byteen", {64'h0, reg3[31:0]}, {64'h0, 32'h11BB33DD});

        weVec = 3'b010; readEnable = 1'b1; address = 8'h01; writeData = 32'h12345678;
        writeByteEnable = 4'hF;
        tick();
        chk("plan_rbw_rd", {64'h0, rd2}, {64'h0, 32'hCCCCCCCC});
        chk("plan_rbw_reg", {64'h0, reg2[63:32]}, {64'h0, 32'h12345678});

        readEnable = 1'b0; address = 8'h02; writeData = 32'hDEADBEEF;
        tick();
        weVec = 3'b000; readEnable = 1'b1;
        tick();
`ifndef MM_REGISTER_ADDR_WRAP_EN
        chk("plan_oor_write", {32'h0, reg2}, {32'h0, 64'h12345678BBBBBBBB});
        chk("plan_oor_read", {64'h0, rd2}, 96'h0);
`endif
        weVec = 3'b010; readEnable = 1'b0; address = 8'h03; writeData = 32'h5A5A5A5A;
        tick();
`ifdef MM_REGISTER_ADDR_WRAP_EN
        chk("plan_wrap", {64'h0, reg2[63:32]}, {64'h0, 32'h5A5A5A5A});
`else
        chk("plan_nowrap", {64'h0, reg2[63:32]}, {64'h0, 32'h12345678});
`endif

        for (int n = 0; n < 400; n++) begin
            reset           = ($urandom_range(0, 24) != 0);
            readEnable      = $urandom_range(0, 1) == 1;
            weVec           = 3'($urandom_range(0, 7));
            writeByteEnable = 4'($urandom_range(0, 15));
            writeData       = $urandom;
            address         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'($urandom_range(0, 4));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mm_register.md
Name: mm_register

Overview:
- Bank of NUM_REGS memory-mapped, software-writable registers with byte-enable writes and a registered read port.
- All register contents are driven continuously on a flat output bus for use by peripheral control logic.
- Sits on a core/bus memory-mapped I/O port. Address is a word index local to the block; the upstream decoder drives the per-instance readEnable/writeEnable.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data buses; must be a multiple of 8.
- ADDR_WIDTH, 8, width of the word-index address input.
- NUM_REGS, 1, number of registers in the bank; must be at least 1 and no more than 2**ADDR_WIDTH.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-low reset.
- register  output  NUM_REGS*DATA_WIDTH  flat concatenation of all registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- readEnable  input  1  read request for the word at address.
- writeEnable  input  1  write request for the word at address.
- writeByteEnable  input  DATA_WIDTH/8  per-byte write mask; bit b enables byte lane b.
- address  input  ADDR_WIDTH  word index of the target register.
- writeData  input  DATA_WIDTH  write data.
- readData  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset: on a rising edge with reset low, all registers are cleared to 0 and readData is cleared to 0. Reset has priority over any concurrent read or write.
- Write:
  - Condition: rising edge, reset high, writeEnable=1, address < NUM_REGS.
  - For each byte lane b with writeByteEnable[b]=1, register[address] byte b takes writeData byte b. Lanes with the mask bit at 0 keep their value.
  - The new value is visible on the register output immediately after that edge (1-cycle latency).
- Out-of-range write (address >= NUM_REGS): ignored; no register changes.
- Read:
  - Condition: rising edge, reset high, readEnable=1.
  - readData takes register[address] if address < NUM_REGS, otherwise 0. Valid after that edge (1-cycle latency).
- readEnable=0: readData holds its previous value.
- Simultaneous read and write to the same address on one edge: readData returns the value held before the write (read-before-write). The register output shows the new value after the edge.
- The register output is purely the stored state, with no combinational path from inputs. Reads have no side effects.
- Every edge is independent; a read or write can be issued each cycle with no handshake or stall.
- NUM_REGS=1: address 0 is the only valid index.

Optional Feature:
- Macro: MM_REGISTER_ADDR_WRAP_EN.
- Defined:
  - Only the low max(1, ceil(log2(NUM_REGS))) bits of address are decoded; upper bits are ignored.
  - If NUM_REGS=1, every address maps to register 0.
  - If the truncated index is still >= NUM_REGS (non-power-of-two NUM_REGS), it is treated as out-of-range, as in the default behaviour.
- Undefined (default): the full address is compared against NUM_REGS, and out-of-range accesses behave as described under Behaviour.

Test Plan:
- Reset: hold reset low 3 cycles with writeEnable=1 and writeData=0xFFFFFFFF -> register output = 0, readData = 0.
- NUM_REGS=1 write: writeEnable=1, address=0, writeByteEnable=0xF, writeData=0xAAAAAAAA -> one edge later register=0xAAAAAAAA. A second NUM_REGS=2 instance on the same bus with its writeEnable low stays 0x0000000000000000.
- NUM_REGS=2 writes:
  - address=0, data=0xBBBBBBBB -> register=0x00000000BBBBBBBB.
  - Then address=1, data=0xCCCCCCCC -> register=0xCCCCCCCCBBBBBBBB.
- Reads: readEnable=1, address=0 -> one edge later readData=0xAAAAAAAA (NUM_REGS=1) and 0xBBBBBBBB (NUM_REGS=2). Dropping readEnable keeps readData unchanged.
- Byte enables: register 0 = 0x11223344; write 0xAABBCCDD with writeByteEnable=0x5 -> 0x11BB33DD.
- Boundaries:
  - Write 0xDEADBEEF to address 2 on NUM_REGS=2 -> no change; read of address 2 returns 0.
  - With MM_REGISTER_ADDR_WRAP_EN defined, NUM_REGS=2, address 0x03 -> register 1 written.
  - Same-edge read and write of address 1 -> readData returns the old value 0xCCCCCCCC.
